mem_port_responder: RTL and testbench

- Memory-side responder for the multicycle RISC-V core.
- Serves load, store and instruction-fetch requests issued by the control FSM over a level req / pulse ack handshake.
- Holds a word-organised RAM with byte-lane writes and sized, sign-/zero-extended reads.
- Inserts a programmable number of wait states; flags misaligned and out-of-range accesses instead of performing them.

---
 rtl/mem_port_responder.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_responder.sv
// Memory-side responder for the multicycle RISC-V core.
// Word-organised RAM with byte-lane stores and sized, extended loads, served
// over a level req / one-cycle ack handshake after WAIT_CYCLES wait states.
// Misaligned, illegal-size and out-of-range accesses are acked with err=1.
module mem_port_responder #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic [3:0][7:0]     r_mem [DEPTH];

    // Access fields: live inputs while idle (needed when WAIT_CYCLES=0 and
    // the access happens on the accept edge), latched copy otherwise.
    logic [ADDR_W-1:0]   w_a_addr;
    logic                w_a_we;
    logic [1:0]          w_a_size;
    logic                w_a_uns;
    logic [31:0]         w_a_wdata;
    logic                w_a_err;
    logic                w_go_resp;
    logic [IDX_W-1:0]    w_idx;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [3:0]          w_be;
    logic [31:0]         w_wlane;

    assign w_a_addr  = (r_state == ST_IDLE) ? addr  : r_addr;
    assign w_a_we    = (r_state == ST_IDLE) ? we    : r_we;
    assign w_a_size  = (r_state == ST_IDLE) ? size  : r_size;
    assign w_a_uns   = (r_state == ST_IDLE) ? uns   : r_uns;
    assign w_a_wdata = (r_state == ST_IDLE) ? wdata : r_wdata;

    // Rejection rules: illegal size, misalignment, word index beyond the RAM.
    assign w_a_err = (w_a_size == 2'b11)
                   || (w_a_size == 2'b01 && w_a_addr[0])
                   || (w_a_size == 2'b10 && w_a_addr[1:0] != 2'b00)
                   || (32'(w_a_addr[ADDR_W-1:2]) >= 32'(DEPTH));

    // The RAM access is performed on the edge that enters RESP.
    assign w_go_resp = (r_state == ST_IDLE && req && WAIT_CYCLES == 0)
                    || (r_state == ST_WAIT && r_cnt == 4'd0);

    assign w_idx  = w_a_addr[IDX_W+1:2];
    assign w_word = r_mem[w_idx];
    assign rdata  = r_rdata;

    // Load lane selection and sign/zero extension.
    always_comb begin
        w_byte = w_word[7:0];
        case (w_a_addr[1:0])
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = w_a_addr[1] ? w_word[31:16] : w_word[15:0];
        case (w_a_size)
            2'b00:   w_load = {{24{~w_a_uns & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~w_a_uns & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        case (w_a_size)
            2'b00: begin
                w_be    = 4'b0001 << w_a_addr[1:0];
                w_wlane = {4{w_a_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_a_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_a_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = w_a_wdata;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state and state-derived outputs.
    always_comb begin
        w_next = r_state;
        ack    = 1'b0;
        err    = 1'b0;
        busy   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) w_next = ST_RESP;
            end
            ST_RESP: begin
                ack    = 1'b1;
                err    = r_err;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (req) begin
                r_addr  <= addr;
                r_we    <= we;
                r_size  <= size;
                r_uns   <= uns;
                r_wdata <= wdata;
                r_err   <= w_a_err;
                r_cnt   <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
            end
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Load result register; forced to 0 on rejection, held across stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (w_go_resp) begin
            if (w_a_err)     r_rdata <= 32'd0;
            else if (!w_a_we) r_rdata <= w_load;
        end
    end

    // RAM write; an asserted rst on the RESP entry edge aborts the store.
    always_ff @(posedge clk) begin
        if (!rst && w_go_resp && w_a_we && !w_a_err) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) r_mem[w_idx][l] <= w_wlane[8*l +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance, directed vector table, handshake sequences and random traffic
// against a byte-addressed memory model.
module tb_mem_port_responder;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, uns;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata, rdata;
    logic        ack, err, busy;
    logic        req0, we0, uns0;
    logic [15:0] addr0;
    logic [1:0]  size0;
    logic [31:0] wdata0, rdata0;
    logic        ack0, err0, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_responder #(.ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .size(size),
        .uns(uns), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    mem_port_responder #(.ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .size(size0),
        .uns(uns0), .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [1:0]  s;
        logic        u;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_e;
    } vec_t;

    vec_t tv [17];

    // Model state: bytes keyed by {instance, byte address}, last load result.
    logic [7:0]  mm [int];
    logic [31:0] model_rd [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction; req rises after a posedge, dropped in the ack cycle.
    task automatic xact(input bit sel, input logic w, input logic [15:0] a,
                        input logic [1:0] s, input logic u, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic e);
        @(posedge clk); #1;
        if (sel) begin
            req0 = 1'b1; we0 = w; addr0 = a; size0 = s; uns0 = u; wdata0 = d;
        end else begin
            req = 1'b1; we = w; addr = a; size = s; uns = u; wdata = d;
        end
        lat = -1; rd = 32'd0; e = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sel ? ack0 : ack) begin
                lat = c;
                rd  = sel ? rdata0 : rdata;
                e   = sel ? err0 : err;
                break;
            end
        end
        req = 1'b0; req0 = 1'b0;
    endtask

    task automatic run_check(input string nm, input bit sel, input logic w,
                             input logic [15:0] a, input logic [1:0] s, input logic u,
                             input logic [31:0] d, input logic [31:0] exp_rd,
                             input logic exp_e);
        int lat; logic [31:0] rd; logic e;
        xact(sel, w, a, s, u, d, lat, rd, e);
        chk({nm, "_lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
        chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_err"}, {31'd0, e}, {31'd0, exp_e});
    endtask

    // Reference: byte-granular memory, alignment by modulo, sign by masking.
    task automatic model_op(input bit sel, input logic w, input logic [15:0] a,
                            input logic [1:0] s, input logic u, input logic [31:0] d,
                            output logic [31:0] exp_rd, output logic exp_e);
        int nb, base;
        logic [31:0] val;
        nb   = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        base = sel * 65536 + int'(a);
        exp_e = (s == 2'b11) || (int'(a) % nb != 0) || (int'(a) / 4 >= DEPTH);
        if (exp_e) begin
            model_rd[sel] = 32'd0;
        end else if (w) begin
            for (int i = 0; i < nb; i++) mm[base + i] = d[8*i +: 8];
        end else begin
            val = 32'd0;
            for (int i = 0; i < nb; i++) val[8*i +: 8] = mm[base + i];
            if (!u && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8*nb)) - 32'h1);
            model_rd[sel] = val;
        end
        exp_rd = model_rd[sel];
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        logic [31:0] erd;
        logic        ee;

        tv[0]  = '{1'b1, 16'h0010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tv[1]  = '{1'b0, 16'h0010, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        tv[2]  = '{1'b1, 16'h0012, 2'b00, 1'b0, 32'h0000005A, 32'hDEADBEEF, 1'b0};
        tv[3]  = '{1'b0, 16'h0012, 2'b00, 1'b0, 32'h0,        32'h0000005A, 1'b0};
        tv[4]  = '{1'b0, 16'h0012, 2'b01, 1'b1, 32'h0,        32'h0000DE5A, 1'b0};
        tv[5]  = '{1'b0, 16'h0010, 2'b01, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0};
        tv[6]  = '{1'b0, 16'h0010, 2'b10, 1'b0, 32'h0,        32'hDE5ABEEF, 1'b0};
        tv[7]  = '{1'b0, 16'h0011, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b1};
        tv[8]  = '{1'b0, 16'h0013, 2'b01, 1'b0, 32'h0,        32'h00000000, 1'b1};
        tv[9]  = '{1'b0, 16'h0010, 2'b11, 1'b0, 32'h0,        32'h00000000, 1'b1};
        tv[10] = '{1'b1, 16'h1000, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        tv[11] = '{1'b0, 16'h0010, 2'b10, 1'b0, 32'h0,        32'hDE5ABEEF, 1'b0};
        tv[12] = '{1'b1, 16'h0016, 2'b01, 1'b0, 32'h00008001, 32'hDE5ABEEF, 1'b0};
        tv[13] = '{1'b0, 16'h0016, 2'b01, 1'b0, 32'h0,        32'hFFFF8001, 1'b0};
        tv[14] = '{1'b0, 16'h0017, 2'b00, 1'b1, 32'h0,        32'h00000080, 1'b0};
        tv[15] = '{1'b1, 16'h0016, 2'b10, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
        tv[16] = '{1'b0, 16'h0016, 2'b01, 1'b0, 32'h0,        32'hFFFF8001, 1'b0};

        rst = 1'b1;
        req = 0; we = 0; uns = 0; addr = '0; size = '0; wdata = '0;
        req0 = 0; we0 = 0; uns0 = 0; addr0 = '0; size0 = '0; wdata0 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst0_rdata", rdata0, 32'd0);
        chk("rst0_busy", {31'd0, busy0}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 17; i++)
            run_check($sformatf("vec%0d", i), 1'b0, tv[i].w, tv[i].a, tv[i].s,
                      tv[i].u, tv[i].d, tv[i].exp_rd, tv[i].exp_e);

        // req held high across four back-to-back loads
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 16'h0010; size = 2'b10; uns = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_ack_c%0d", c), {31'd0, ack}, {31'd0, (c % 4 == 3)});
            chk($sformatf("b2b_busy_c%0d", c), {31'd0, busy}, {31'd0, (c % 4 != 0)});
            if (c % 4 == 3) chk($sformatf("b2b_rdata_c%0d", c), rdata, 32'hDE5ABEEF);
            if (c == 15) req = 1'b0;
        end

        // Reset during WAIT aborts a store
        run_check("pre_st", 1'b0, 1'b1, 16'h0020, 2'b10, 1'b0, 32'hCAFEF00D, 32'hDE5ABEEF, 1'b0);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'h0020; size = 2'b10; wdata = 32'h12345678;
        @(negedge clk);
        chk("abort_ack_c0", {31'd0, ack}, 32'd0);
        @(posedge clk); #1; req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_ack", {31'd0, ack}, 32'd0);
        chk("abort_rst_err", {31'd0, err}, 32'd0);
        chk("abort_rst_busy", {31'd0, busy}, 32'd0);
        chk("abort_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_ack", {31'd0, ack}, 32'd0);
        end
        run_check("abort_ld", 1'b0, 1'b0, 16'h0020, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);

        // Zero wait states
        run_check("w0_st", 1'b1, 1'b1, 16'h0040, 2'b10, 1'b0, 32'hA5A51234, 32'd0, 1'b0);
        run_check("w0_ldb", 1'b1, 1'b0, 16'h0043, 2'b00, 1'b0, 32'h0, 32'hFFFFFFA5, 1'b0);
        run_check("w0_ld", 1'b1, 1'b0, 16'h0040, 2'b10, 1'b0, 32'h0, 32'hA5A51234, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("w0_hold_rdata", rdata0, 32'hA5A51234);
            chk("w0_hold_ack", {31'd0, ack0}, 32'd0);
        end

        // Random traffic against the model, from a known post-reset rdata
        pulse_reset();
        model_rd[0] = 32'd0;
        model_rd[1] = 32'd0;
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 16; i++) begin
                logic [31:0] d;
                d = $urandom;
                model_op(sel[0], 1'b1, 16'(16'h0100 + 4 * i), 2'b10, 1'b0, d, erd, ee);
                run_check("rnd_init", sel[0], 1'b1, 16'(16'h0100 + 4 * i), 2'b10, 1'b0, d, erd, ee);
            end
            for (int i = 0; i < 120; i++) begin
                logic        w, u;
                logic [15:0] a;
                logic [1:0]  s;
                logic [31:0] d;
                w = 1'($urandom_range(0, 1));
                u = 1'($urandom_range(0, 1));
                s = 2'($urandom_range(0, 3));
                d = $urandom;
                if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(4 * DEPTH, 16'hFFFF));
                else                           a = 16'(16'h0100 + $urandom_range(0, 63));
                model_op(sel[0], w, a, s, u, d, erd, ee);
                run_check($sformatf("rnd%0d_%0d", sel, i), sel[0], w, a, s, u, d, erd, ee);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
